buffer_module: RTL and testbench
================================

Name: buffer_module

Overview:
- Small synchronous word buffer: 16 entries x 16 bits, with a single write port and a single registered read port sharing one address bus.
- Provides sample or coefficient storage between a producer that writes individual words and a consumer that reads them back by address.
- Single clock domain (clk).
- Synchronous, active-high reset (rst) clears all contents and status.

Parameters:
- DATA_W, 16, width of each stored word and of data_in/data_out.
- ADDR_W, 4, address width; depth = 2**ADDR_W (default 16).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- address  in  ADDR_W  entry selected for both write and read.
- data_in  in  DATA_W  write data.
- write  in  1  write strobe, sampled at rising clk.
- output_enable  in  1  read enable, sampled at rising clk.
- operational_clock  in  1  interface-compatibility input; must be tied to clk; ignored internally (no logic, no second domain).
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  registered; 1 when the entry read this cycle has been written since reset.
- word_count  out  ADDR_W+1  number of distinct entries written since reset (0..depth).

Behaviour:
- Reset (rst=1 at rising clk):
  - all memory words cleared to 0; all per-entry valid bits cleared.
  - data_out=0, data_valid=0, word_count=0.
  - rst has priority over write and output_enable in the same cycle.
- Write: at rising clk with write=1 and rst=0, mem[address] <= data_in and valid[address] <= 1.
- word_count:
  - increments by 1 only when the written entry was previously invalid.
  - rewriting an already-valid entry leaves word_count unchanged.
  - saturates at depth.
- Read (output_enable=1 at rising clk):
  - data_out <= mem[address], data_valid <= valid[address]; 1-cycle latency.
  - If output_enable=0: data_out <= 0, data_valid <= 0.
- Simultaneous write and read to the same address: write-first bypass, so data_out takes the new data_in and data_valid=1.
- Write and read both use the same address bus; no separate read address.
- X or unknown address while write=1: simulation behaviour is undefined; no protection required in RTL.
- No wrap-around or overflow concept: addresses index directly, and all 2**ADDR_W values are legal.
- Reset mid-operation discards any write presented in the same cycle.

Optional Feature:
- Macro BUFFER_MODULE_TRISTATE_EN.
- Defined: when output_enable=0, data_out is driven high-impedance (all Z) combinationally from the registered enable. The internal read register still clears to 0.
- Undefined (default): data_out is a plain register driving 0 when disabled, as above.
- data_valid behaviour is identical in both builds.

Decomposition:
- Package buffer_pkg holds DATA_W/ADDR_W defaults, the DEPTH constant and a word_t typedef.
- One natural sub-module, buffer_mem: the storage array plus valid bitmap with its write logic.
- The top level holds the read register, bypass mux, word counter and tri-state option.

Test Plan:
- Reset: assert rst for 2 cycles, then read addresses 0..15 with output_enable=1 -> data_out=0, data_valid=0, word_count=0.
- Sequential writes: write 123@0, 234@1, 345@2, then read 0, 1, 2 -> data_out 123, 234, 345 on successive cycles, each one cycle after the address, data_valid=1, word_count=3.
- Rewrite: write 999@1 after the above, read 1 -> 999; word_count stays 3.
- Bypass: in the same cycle write=1, output_enable=1, address 5, data_in 0x5A5A -> next cycle data_out=0x5A5A, data_valid=1.
- Disable: output_enable=0 for one cycle while address=0 -> data_out=0 (Z with BUFFER_MODULE_TRISTATE_EN), data_valid=0; memory unchanged on re-read.
- Reset priority: rst=1 with write=1 to address 3 -> after release, read 3 gives 0 with data_valid=0. Fill all 16 entries -> word_count=16; a 17th write to any entry -> word_count stays 16.

Source files
------------

// File: rtl/buffer_pkg.sv
// ---------------------------------------------------------------------------
// buffer_pkg
// Shared constants and types for the 16 x 16 word buffer.
//   BUF_DATA_W : default stored word width
//   BUF_ADDR_W : default address width
//   BUF_DEPTH  : default number of entries (2**BUF_ADDR_W)
//   word_t     : one stored word at the default width
// ---------------------------------------------------------------------------
package buffer_pkg;

  localparam int BUF_DATA_W = 16;
  localparam int BUF_ADDR_W = 4;
  localparam int BUF_DEPTH  = 2 ** BUF_ADDR_W;

  typedef logic [BUF_DATA_W-1:0] word_t;

endpackage : buffer_pkg

// File: rtl/buffer_mem.sv
// ---------------------------------------------------------------------------
// buffer_mem
// Storage array plus per-entry valid bitmap. Reset clears every word and
// every valid bit; a write stores the word and marks the entry valid.
// The read side is purely combinational (indexed by the same address) so the
// top level can register it and apply the write-first bypass.
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset (wins over we_i)
//   we_i      : write strobe
//   addr_i    : entry address (write and read)
//   wdata_i   : write data
//   rdata_o   : current contents of mem[addr_i]
//   rvalid_o  : current valid bit of entry addr_i
// ---------------------------------------------------------------------------
module buffer_mem
  import buffer_pkg::*;
#(
  parameter int DATA_W = BUF_DATA_W,
  parameter int ADDR_W = BUF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (we_i) begin
      mem_q[addr_i]   <= wdata_i;
      valid_q[addr_i] <= 1'b1;
    end
  end

  assign rdata_o  = mem_q[addr_i];
  assign rvalid_o = valid_q[addr_i];

endmodule : buffer_mem

// File: rtl/buffer_module.sv
// ---------------------------------------------------------------------------
// buffer_module
// 16 x 16 synchronous word buffer with one write port and one registered
// read port sharing a single address bus.
// Ports:
//   clk               : system clock, all updates on rising edge
//   rst               : synchronous active-high reset, clears contents/status
//   address           : entry selected for both write and read
//   data_in           : write data
//   write             : write strobe
//   output_enable     : read enable
//   operational_clock : legacy interface input, tied to clk, not used
//   data_out          : registered read data
//   data_valid        : registered, entry read has been written since reset
//   word_count        : distinct entries written since reset (0..depth)
// Build option:
//   BUFFER_MODULE_TRISTATE_EN : when defined, data_out floats (all Z) in any
//   cycle whose registered read enable is low.
// ---------------------------------------------------------------------------
module buffer_module
  import buffer_pkg::*;
#(
  parameter int DATA_W = BUF_DATA_W,
  parameter int ADDR_W = BUF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write,
  input  logic              output_enable,
  input  logic              operational_clock,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned     DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  // Present only for pin compatibility; deliberately drives nothing.
  logic unused_operational_clock;
  assign unused_operational_clock = operational_clock;

  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  buffer_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .we_i     (write),
    .addr_i   (address),
    .wdata_i  (data_in),
    .rdata_o  (mem_rdata),
    .rvalid_o (mem_rvalid)
  );

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              oe_q;
  logic [ADDR_W:0]   count_q, count_d;

  // Read timing: address and output_enable sampled at edge N produce
  // data_out/data_valid after edge N (one-cycle latency). A write to the
  // same address in that cycle is forwarded (write-first). With the enable
  // low the register loads zero and data_valid drops.
  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
    if (output_enable) begin
      if (write) begin
        rd_data_d  = data_in;
        rd_valid_d = 1'b1;
      end else begin
        rd_data_d  = mem_rdata;
        rd_valid_d = mem_rvalid;
      end
    end
  end

  // Only first writes to an entry grow the count; rewrites do not.
  always_comb begin
    count_d = count_q;
    if (write && !mem_rvalid && (count_q != FULL_CNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      oe_q       <= 1'b0;
      count_q    <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      oe_q       <= output_enable;
      count_q    <= count_d;
    end
  end

`ifdef BUFFER_MODULE_TRISTATE_EN
  assign data_out = oe_q ? rd_data_q : {DATA_W{1'bz}};
`else
  assign data_out = rd_data_q;
`endif

  assign data_valid = rd_valid_q;
  assign word_count = count_q;

endmodule : buffer_module

// File: tb/tb_buffer_module.sv
// ---------------------------------------------------------------------------
// tb_buffer_module
// Directed-vector bench. The driver applies one vector per clock and pushes
// the hand-computed response expected after that edge; an independent
// monitor pops and compares after every rising edge.
// ---------------------------------------------------------------------------
module tb_buffer_module;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              write;
  logic              output_enable;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic              exp_v_q[$];
  logic [ADDR_W:0]   exp_c_q[$];
  string             exp_n_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  buffer_module #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .address           (address),
    .data_in           (data_in),
    .write             (write),
    .output_enable     (output_enable),
    .operational_clock (clk),
    .data_out          (data_out),
    .data_valid        (data_valid),
    .word_count        (word_count)
  );

  // ---------------- driver ----------------
  // Drives on the falling edge, records what must appear after the next
  // rising edge, then waits for that edge.
  task automatic cycle(input logic r, input logic we, input logic oe,
                       input int a, input int din,
                       input int edata, input logic evalid, input int ecount,
                       input string name);
    logic [DATA_W-1:0] ed;
    @(negedge clk);
    rst           = r;
    write         = we;
    output_enable = oe;
    address       = a[ADDR_W-1:0];
    data_in       = din[DATA_W-1:0];
    ed            = edata[DATA_W-1:0];
`ifdef BUFFER_MODULE_TRISTATE_EN
    if (!oe || r) ed = {DATA_W{1'bz}};
`endif
    exp_q.push_back(ed);
    exp_v_q.push_back(evalid);
    exp_c_q.push_back(ecount[ADDR_W:0]);
    exp_n_q.push_back(name);
    @(posedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [DATA_W-1:0] ed;
      logic              ev;
      logic [ADDR_W:0]   ec;
      string             nm;
      ed = exp_q.pop_front();
      ev = exp_v_q.pop_front();
      ec = exp_c_q.pop_front();
      nm = exp_n_q.pop_front();
      checks++;
      if (data_out !== ed) begin
        errors++;
        $display("FAIL %s data_out got %h expected %h", nm, data_out, ed);
      end
      checks++;
      if (data_valid !== ev) begin
        errors++;
        $display("FAIL %s data_valid got %b expected %b", nm, data_valid, ev);
      end
      checks++;
      if (word_count !== ec) begin
        errors++;
        $display("FAIL %s word_count got %0d expected %0d", nm, word_count, ec);
      end
    end
  end

  // ---------------- directed vectors ----------------
  initial begin
    int wait_cycles;
    rst = 1'b1; write = 1'b0; output_enable = 1'b0;
    address = '0; data_in = '0;

    // reset held two cycles
    cycle(1, 0, 0, 0, 0, 0, 0, 0, "reset0");
    cycle(1, 0, 0, 0, 0, 0, 0, 0, "reset1");

    // every entry reads zero and invalid after reset
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, i, 0, 0, 0, 0, "reset_read");

    // sequential writes then reads
    cycle(0, 1, 0, 0, 123, 0, 0, 1, "wr0");
    cycle(0, 1, 0, 1, 234, 0, 0, 2, "wr1");
    cycle(0, 1, 0, 2, 345, 0, 0, 3, "wr2");
    cycle(0, 0, 1, 0, 0, 123, 1, 3, "rd0");
    cycle(0, 0, 1, 1, 0, 234, 1, 3, "rd1");
    cycle(0, 0, 1, 2, 0, 345, 1, 3, "rd2");
    cycle(0, 0, 1, 9, 0, 0, 0, 3, "rd_unwritten");

    // rewrite keeps the count
    cycle(0, 1, 0, 1, 999, 0, 0, 3, "rewr1");
    cycle(0, 0, 1, 1, 0, 999, 1, 3, "rd_rewr1");

    // write-first bypass
    cycle(0, 1, 1, 5, 16'h5A5A, 16'h5A5A, 1, 4, "bypass");
    cycle(0, 0, 1, 5, 0, 16'h5A5A, 1, 4, "rd_bypass");

    // read disabled, then memory still intact
    cycle(0, 0, 0, 0, 0, 0, 0, 4, "disable");
    cycle(0, 0, 1, 0, 0, 123, 1, 4, "reread0");

    // reset beats a same-cycle write and read
    cycle(1, 1, 1, 3, 16'h7777, 0, 0, 0, "rst_prio");
    cycle(0, 0, 1, 3, 0, 0, 0, 0, "rd3_after_rst");
    cycle(0, 0, 1, 0, 0, 0, 0, 0, "rd0_after_rst");

    // fill all entries, count to 16 then saturate
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, i, i * 16 + 1, 0, 0, i + 1, "fill");
    cycle(0, 0, 1, 15, 0, 241, 1, 16, "rd15_full");
    cycle(0, 1, 0, 7, 16'hBEEF, 0, 0, 16, "wr17_sat");
    cycle(0, 0, 1, 7, 0, 16'hBEEF, 1, 16, "rd7_sat");
    cycle(0, 0, 1, 8, 0, 129, 1, 16, "rd8_full");

    // drain the scoreboard with a bounded wait
    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_buffer_module
